// File: rtl/cr_cddip_drain_ctl_pkg.sv
// Shared types and default sizing for the CDDIP drain/halt control slice.
package cr_cddip_supportPKG;

    localparam int unsigned CDDIP_CNT_W_DFLT    = 10;
    localparam int unsigned CDDIP_TO_W_DFLT     = 16;
    localparam int unsigned CDDIP_IDLE_DLY_DFLT = 4;

    // Encoding 3 is unused; the FSM falls back to RUN if it is ever seen.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } drain_state_e;

endpackage

// File: rtl/cr_cddip_inflight_cnt.sv
// Saturating in-flight command counter with over/underflow pulse and
// debounced idle indication.
module cr_cddip_inflight_cnt
    import cr_cddip_supportPKG::*;
#(
    parameter int unsigned CNT_W    = CDDIP_CNT_W_DFLT,
    parameter int unsigned IDLE_DLY = CDDIP_IDLE_DLY_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_up,
    input  logic             cnt_dn,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_err,
    output logic             idle
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       RUN_ONE  = 4'd1;
    localparam logic [3:0]       IDLE_MAX = IDLE_DLY[3:0];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [3:0]       run_q, run_d;
    logic             idle_q, idle_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (cnt_up && !cnt_dn) begin
            if (&cnt_q) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (cnt_dn && !cnt_up) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Zero-run is judged on the registered count, so idle lags the count by one cycle.
    always_comb begin
        run_d = run_q;
        if (cnt_q != '0) begin
            run_d = '0;
        end else if (run_q != IDLE_MAX) begin
            run_d = run_q + RUN_ONE;
        end
        idle_d = (run_d == IDLE_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            run_q  <= '0;
            idle_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            run_q  <= run_d;
            idle_q <= idle_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_err = err_q;
    assign idle    = idle_q;

endmodule

// File: rtl/cr_cddip_drain_ctl.sv
// CDDIP quiesce sequencer: tracks in-flight commands and runs the
// drain-then-halt FSM that drives the OSF halt.
module cr_cddip_drain_ctl
    import cr_cddip_supportPKG::*;
#(
    parameter int unsigned CNT_W    = CDDIP_CNT_W_DFLT,
    parameter int unsigned TO_W     = CDDIP_TO_W_DFLT,
    parameter int unsigned IDLE_DLY = CDDIP_IDLE_DLY_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             isf_sup_cqe_rx,
    input  logic             osf_sup_cqe_exit,
    input  logic             cfg_halt_req,
    input  logic             cfg_halt_release,
    input  logic [TO_W-1:0]  cfg_drain_timeout,
    output logic             sup_osf_halt,
    output logic             cddip_idle,
    output logic             halt_ack,
    output logic             halt_forced,
    output logic             drain_timeout_int,
    output logic             cnt_err_int,
    output logic [CNT_W-1:0] inflight_cnt,
    output logic [1:0]       drain_state
);

    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    drain_state_e    state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            armed_q, armed_d;
    logic            forced_q, forced_d;
    logic            tint_q, tint_d;
    logic            halt_q;
    logic            idle;

    cr_cddip_inflight_cnt #(
        .CNT_W    (CNT_W),
        .IDLE_DLY (IDLE_DLY)
    ) u_inflight_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_up  (isf_sup_cqe_rx),
        .cnt_dn  (osf_sup_cqe_exit),
        .cnt     (inflight_cnt),
        .cnt_err (cnt_err_int),
        .idle    (idle)
    );

    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        forced_d = forced_q;
        tint_d   = 1'b0;
        armed_d  = armed_q;
        if (!cfg_halt_req) begin
            armed_d = 1'b1;
        end
        case (state_q)
            RUN: begin
                if (cfg_halt_req && armed_q) begin
                    state_d = DRAIN;
                    to_d    = '0;
                end
            end
            DRAIN: begin
                if (!(&to_q)) begin
                    to_d = to_q + TO_ONE;
                end
                // Abort beats idle, idle beats timeout.
                if (cfg_halt_release || !cfg_halt_req) begin
                    state_d = RUN;
                end else if (idle) begin
                    state_d  = HALTED;
                    forced_d = 1'b0;
                    armed_d  = 1'b0;
                end else if ((cfg_drain_timeout != '0) &&
                             (to_q == cfg_drain_timeout - TO_ONE)) begin
                    state_d  = HALTED;
                    forced_d = 1'b1;
                    tint_d   = 1'b1;
                    armed_d  = 1'b0;
                end
            end
            HALTED: begin
                if (cfg_halt_release) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            to_q     <= '0;
            armed_q  <= 1'b1;
            forced_q <= 1'b0;
            tint_q   <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_q     <= to_d;
            armed_q  <= armed_d;
            forced_q <= forced_d;
            tint_q   <= tint_d;
            halt_q   <= (state_d == HALTED);
        end
    end

    assign sup_osf_halt      = halt_q;
    assign halt_ack          = halt_q;
    assign cddip_idle        = idle;
    assign halt_forced       = forced_q;
    assign drain_timeout_int = tint_q;
    assign drain_state       = state_q;

endmodule

// File: tb/tb_cr_cddip_drain_ctl.sv
// Directed bench for cr_cddip_drain_ctl: vector table plus hand-written
// timeout, async-reset and counter-saturation sequences.
module tb_cr_cddip_drain_ctl;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned TO_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             isf_sup_cqe_rx;
    logic             osf_sup_cqe_exit;
    logic             cfg_halt_req;
    logic             cfg_halt_release;
    logic [TO_W-1:0]  cfg_drain_timeout;
    logic             sup_osf_halt;
    logic             cddip_idle;
    logic             halt_ack;
    logic             halt_forced;
    logic             drain_timeout_int;
    logic             cnt_err_int;
    logic [CNT_W-1:0] inflight_cnt;
    logic [1:0]       drain_state;

    int checks = 0;
    int errors = 0;

    cr_cddip_drain_ctl #(
        .CNT_W    (CNT_W),
        .TO_W     (TO_W),
        .IDLE_DLY (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .isf_sup_cqe_rx    (isf_sup_cqe_rx),
        .osf_sup_cqe_exit  (osf_sup_cqe_exit),
        .cfg_halt_req      (cfg_halt_req),
        .cfg_halt_release  (cfg_halt_release),
        .cfg_drain_timeout (cfg_drain_timeout),
        .sup_osf_halt      (sup_osf_halt),
        .cddip_idle        (cddip_idle),
        .halt_ack          (halt_ack),
        .halt_forced       (halt_forced),
        .drain_timeout_int (drain_timeout_int),
        .cnt_err_int       (cnt_err_int),
        .inflight_cnt      (inflight_cnt),
        .drain_state       (drain_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rx, ex, req, rel;
        int         cnt;
        logic       idle, err;
        int         st;
        logic       halt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rx, input logic ex, input logic req, input logic rel,
                       input int cnt, input logic idle, input logic err,
                       input int st, input logic halt);
        vec_t v;
        v.rx = rx; v.ex = ex; v.req = req; v.rel = rel;
        v.cnt = cnt; v.idle = idle; v.err = err; v.st = st; v.halt = halt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rx, input logic ex, input logic req, input logic rel);
        isf_sup_cqe_rx   = rx;
        osf_sup_cqe_exit = ex;
        cfg_halt_req     = req;
        cfg_halt_release = rel;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"},    int'(inflight_cnt), 0);
        chk({tag, "_state"},  int'(drain_state), 0);
        chk({tag, "_halt"},   int'(sup_osf_halt), 0);
        chk({tag, "_ack"},    int'(halt_ack), 0);
        chk({tag, "_idle"},   int'(cddip_idle), 0);
        chk({tag, "_forced"}, int'(halt_forced), 0);
        chk({tag, "_tint"},   int'(drain_timeout_int), 0);
        chk({tag, "_err"},    int'(cnt_err_int), 0);
    endtask

    initial begin
        // rx ex req rel | cnt idle err state halt
        add(1,0,0,0, 1,0,0,0,0);
        add(1,0,0,0, 2,0,0,0,0);
        add(1,0,0,0, 3,0,0,0,0);
        add(0,1,0,0, 2,0,0,0,0);
        add(0,1,0,0, 1,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,1,0,0,0);  // idle 4 edges after count hit 0
        add(1,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 2,0,0,0,0);  // idle falls one cycle after nonzero
        add(1,0,0,0, 3,0,0,0,0);
        add(1,0,0,0, 4,0,0,0,0);
        add(1,0,0,0, 5,0,0,0,0);
        add(1,1,0,0, 5,0,0,0,0);  // simultaneous rx/exit
        add(0,1,0,0, 4,0,0,0,0);
        add(0,1,0,0, 3,0,0,0,0);
        add(0,1,0,0, 2,0,0,0,0);
        add(0,1,0,0, 1,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0);
        add(0,1,0,0, 0,0,1,0,0);  // underflow
        add(0,0,0,0, 0,0,0,0,0);
        add(1,0,0,0, 1,0,0,0,0);
        add(1,0,0,0, 2,0,0,0,0);
        add(0,0,1,0, 2,0,0,1,0);  // drain, timeout disabled
        add(0,1,1,0, 1,0,0,1,0);
        add(0,1,1,0, 0,0,0,1,0);
        add(0,0,1,0, 0,0,0,1,0);
        add(0,0,1,0, 0,0,0,1,0);
        add(0,0,1,0, 0,0,0,1,0);
        add(0,0,1,0, 0,1,0,1,0);
        add(0,0,1,0, 0,1,0,2,1);  // idle halt
        add(0,0,1,0, 0,1,0,2,1);
        add(0,0,1,1, 0,1,0,0,0);  // release, req still high
        add(0,0,1,0, 0,1,0,0,0);  // not re-armed
        add(0,0,0,0, 0,1,0,0,0);
        add(0,0,1,0, 0,1,0,1,0);  // re-armed
        add(0,0,1,0, 0,1,0,2,1);
        add(0,0,0,0, 0,1,0,2,1);
        add(0,0,0,1, 0,1,0,0,0);
        add(0,0,1,0, 0,1,0,1,0);
        add(0,0,0,0, 0,1,0,0,0);  // req drop aborts despite idle
        add(0,0,1,0, 0,1,0,1,0);
        add(0,0,1,1, 0,1,0,0,0);  // release beats idle
        add(0,0,0,0, 0,1,0,0,0);

        cfg_drain_timeout = '0;
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rx, tbl[i].ex, tbl[i].req, tbl[i].rel);
            tick();
            chk($sformatf("v%0d_cnt", i),    int'(inflight_cnt), tbl[i].cnt);
            chk($sformatf("v%0d_idle", i),   int'(cddip_idle), int'(tbl[i].idle));
            chk($sformatf("v%0d_err", i),    int'(cnt_err_int), int'(tbl[i].err));
            chk($sformatf("v%0d_state", i),  int'(drain_state), tbl[i].st);
            chk($sformatf("v%0d_halt", i),   int'(sup_osf_halt), int'(tbl[i].halt));
            chk($sformatf("v%0d_ack", i),    int'(halt_ack), int'(tbl[i].halt));
            chk($sformatf("v%0d_forced", i), int'(halt_forced), 0);
            chk($sformatf("v%0d_tint", i),   int'(drain_timeout_int), 0);
        end

        // Timeout: count=1, timeout 20, no exits
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0); tick(); tick();
        chk("to_pre_idle", int'(cddip_idle), 0);
        cfg_drain_timeout = 16'd20;
        drive(0, 0, 1, 0); tick();
        chk("to_entry_state", int'(drain_state), 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k < 20) begin
                chk($sformatf("to_k%0d_state", k), int'(drain_state), 1);
                chk($sformatf("to_k%0d_tint", k), int'(drain_timeout_int), 0);
            end
        end
        chk("to_state",  int'(drain_state), 2);
        chk("to_tint",   int'(drain_timeout_int), 1);
        chk("to_forced", int'(halt_forced), 1);
        chk("to_halt",   int'(sup_osf_halt), 1);
        tick();
        chk("to_tint_once", int'(drain_timeout_int), 0);
        chk("to_forced_sticky", int'(halt_forced), 1);
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 0);
        chk("to_release_state", int'(drain_state), 0);
        chk("to_release_halt",  int'(sup_osf_halt), 0);

        // Async reset while HALTED with count 7
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0);
        chk("rst_pre_cnt", int'(inflight_cnt), 7);
        cfg_drain_timeout = 16'd3;
        drive(0, 0, 1, 0);
        repeat (4) tick();
        chk("rst_pre_state", int'(drain_state), 2);
        chk("rst_pre_forced", int'(halt_forced), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        drive(0, 0, 0, 0);
        tick();
        chk_all_zero("arst_edge");
        rst_n = 1'b1;
        cfg_drain_timeout = '0;

        // Overflow at all-ones
        drive(1, 0, 0, 0);
        for (int k = 0; k < 1023; k++) tick();
        chk("ovf_full_cnt", int'(inflight_cnt), 1023);
        chk("ovf_full_err", int'(cnt_err_int), 0);
        tick();
        chk("ovf_cnt", int'(inflight_cnt), 1023);
        chk("ovf_err", int'(cnt_err_int), 1);
        drive(1, 1, 0, 0); tick();
        chk("ovf_both_cnt", int'(inflight_cnt), 1023);
        chk("ovf_both_err", int'(cnt_err_int), 0);
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 0, 0);
        chk("ovf_dec_cnt", int'(inflight_cnt), 1022);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cr_cddip_drain_ctl.md
Name: cr_cddip_drain_ctl

Overview:
- Sequences quiesce/halt of the CDDIP pipe.
- Tracks commands in flight between ISF entry and OSF exit, and generates a debounced idle indication.
- Runs a drain-then-halt state machine, driven by register-file control bits, that drives the OSF halt.
- Sits beside the support core; its outputs feed cddip_idle, sup_osf_halt and the support interrupt/status registers.

Parameters:
- CNT_W, 10, width of in-flight command counter
- TO_W, 16, width of drain timeout counter/config
- IDLE_DLY, 4, consecutive zero-count cycles required before idle asserts (range 1..15)

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- isf_sup_cqe_rx  input  1  single-cycle pulse: command entered ISF (count up)
- osf_sup_cqe_exit  input  1  single-cycle pulse: command left OSF (count down)
- cfg_halt_req  input  1  level from regfile: request drain and halt
- cfg_halt_release  input  1  single-cycle pulse from regfile: release halt/abort drain
- cfg_drain_timeout  input  TO_W  drain timeout in cycles; 0 disables timeout
- sup_osf_halt  output  1  halt to OSF (registered)
- cddip_idle  output  1  debounced pipe idle (registered)
- halt_ack  output  1  halted status to regfile (registered)
- halt_forced  output  1  sticky: last halt entered via timeout
- drain_timeout_int  output  1  single-cycle interrupt pulse on timeout
- cnt_err_int  output  1  single-cycle pulse on counter overflow/underflow
- inflight_cnt  output  CNT_W  current in-flight count
- drain_state  output  2  FSM state encoding for status

Behaviour:
- Reset values: all outputs 0, state RUN, counters 0.
- In-flight counter, updated each cycle:
  - rx only: +1.
  - exit only: -1.
  - rx and exit in the same cycle: unchanged, no error.
  - +1 at all-ones: hold the value and pulse cnt_err_int.
  - -1 at 0: hold 0 and pulse cnt_err_int.
- inflight_cnt is the register value; 1-cycle latency from the pulse.
- Idle debounce:
  - A zero-run counter increments while inflight_cnt==0 and saturates at IDLE_DLY.
  - Any nonzero count clears it.
  - cddip_idle = (run counter == IDLE_DLY), registered. It falls the cycle after the count becomes nonzero.
- FSM states: RUN=0, DRAIN=1, HALTED=2; encoding 3 unused and returns to RUN.
  - RUN: when cfg_halt_req=1, go to DRAIN and clear the timeout counter.
  - DRAIN: sup_osf_halt stays 0 so OSF can finish outstanding work.
    - Timeout counter increments each cycle.
    - If cddip_idle=1: go to HALTED, clear halt_forced.
    - Else if cfg_drain_timeout!=0 and the timeout counter reaches cfg_drain_timeout-1: go to HALTED, set halt_forced, pulse drain_timeout_int once.
    - cfg_halt_release, or cfg_halt_req dropping to 0: abort back to RUN with no interrupt.
    - Priority: release > idle > timeout.
  - HALTED: sup_osf_halt=1 and halt_ack=1, both registered and asserted the cycle after entry.
    - cfg_halt_release: go to RUN; halt deasserts the next cycle.
    - cfg_halt_req remaining high does not re-enter DRAIN until it has been seen low once. A req_armed flag is cleared on HALTED entry and set when req==0.
- Counting continues in every state; rx/exit are never blocked.
- halt_forced is cleared on the next normal idle halt or on reset.
- Asynchronous reset mid-drain or mid-halt returns immediately to RUN with halt=0 and count=0.
- A cfg_drain_timeout change during DRAIN takes effect on the next compare.

Decomposition:
- cr_cddip_supportPKG holds:
  - drain_state_e enum (RUN, DRAIN, HALTED).
  - Default constants for CNT_W, TO_W and IDLE_DLY.
- One sub-module, cr_cddip_inflight_cnt, covers the saturating up/down counter, error pulse and idle debounce.
- The FSM and timeout logic live in the top.

Test Plan:
- Reset, then 3 rx pulses, then 3 exit pulses -> inflight_cnt 1,2,3,2,1,0; cddip_idle=0 throughout, rising exactly 4 cycles after the count reaches 0.
- rx and exit in the same cycle with count=5 -> count stays 5; no cnt_err_int. Exit at count 0 -> count 0 and cnt_err_int pulses for 1 cycle.
- count=2, assert cfg_halt_req, timeout=0 -> drain_state=1 and sup_osf_halt=0. After 2 exits plus IDLE_DLY cycles: state=2, sup_osf_halt=1, halt_ack=1, halt_forced=0.
- count=1, halt_req with cfg_drain_timeout=20 and no exits -> drain_timeout_int single pulse 20 cycles after DRAIN entry; HALTED with halt_forced=1.
- In HALTED, pulse cfg_halt_release with req still high -> RUN; no re-drain until req has gone low then high again.
- Assert rst_n=0 while HALTED with count=7 -> next edge shows all outputs 0 and state RUN.
